// File: rtl/pdw_snapshot_engine.sv
// PDW snapshot engine: threshold trigger, pre/post window capture, serial PDW (MSB first).
// Define PDW_CRC_EN to append a CRC-16-CCITT (0x1021, init 0xFFFF) after the last sample.
module pdw_snapshot_engine #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIR_WIDTH    = 36,
  parameter int PRE_SAMPLES  = 4,
  parameter int POST_SAMPLES = 6,
  parameter int TIME_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic [FIR_WIDTH-1:0]    fir_i,
  input  logic                    valid_i,
  input  logic                    cfg_en_i,
  input  logic [FIR_WIDTH-1:0]    cfg_thresh_hi_i,
  input  logic [FIR_WIDTH-1:0]    cfg_thresh_lo_i,
  input  logic [15:0]             cfg_holdoff_i,
  output logic                    pdw_data,
  output logic                    pdw_frame,
  output logic                    busy_o,
  output logic [7:0]              missed_o
);
  localparam int W         = PRE_SAMPLES + POST_SAMPLES;
  localparam int HIST_BITS = PRE_SAMPLES * SAMPLE_WIDTH;
  localparam int WIN_BITS  = W * SAMPLE_WIDTH;
  localparam int DATA_BITS = TIME_WIDTH + FIR_WIDTH + WIN_BITS;
`ifdef PDW_CRC_EN
  localparam int CRC_BITS  = 16;
`else
  localparam int CRC_BITS  = 0;
`endif
  localparam int FRAME_LEN = DATA_BITS + CRC_BITS;
  localparam int CW        = $clog2(FRAME_LEN + 1);
  localparam int PW        = $clog2(POST_SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, TX, HOLDOFF} state_t;
  state_t state, state_n;

  logic [TIME_WIDTH-1:0]             ts, ts_q;
  logic [FIR_WIDTH-1:0]              fir_q;
  logic [HIST_BITS-1:0]              hist;
  logic [HIST_BITS+SAMPLE_WIDTH-1:0] hist_ext;
  logic [WIN_BITS-1:0]               win, win_n;
  logic [DATA_BITS-1:0]              sr, frame_vec;
  logic [CW-1:0]                     bit_cnt;
  logic [PW-1:0]                     post_cnt;
  logic [15:0]                       hold_cnt;
  logic hi_hit, lo_hit, trig, take, load, tx_done, hold_done;

  assign hi_hit    = $signed(fir_i) >= $signed(cfg_thresh_hi_i);
  assign lo_hit    = $signed(fir_i) <= $signed(cfg_thresh_lo_i);
  assign trig      = valid_i & cfg_en_i & (hi_hit | lo_hit);
  assign take      = trig && (state == IDLE);
  assign load      = (take && POST_SAMPLES == 1) ||
                     (state == CAPTURE && valid_i && post_cnt == PW'(POST_SAMPLES - 1));
  assign tx_done   = (state == TX) && (bit_cnt == CW'(FRAME_LEN));
  assign hold_done = (state == HOLDOFF) && valid_i &&
                     (({1'b0, hold_cnt} + 17'd1) >= {1'b0, cfg_holdoff_i});
  assign busy_o    = (state != IDLE);
  assign hist_ext  = {hist, sample_i};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = (POST_SAMPLES == 1) ? TX : CAPTURE;
      CAPTURE: if (load) state_n = TX;
      TX:      if (tx_done) state_n = (cfg_holdoff_i == 16'd0) ? IDLE : HOLDOFF;
      HOLDOFF: if (hold_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Window fills from the LSB end; after the last post sample the zero pad has shifted out.
  always_comb begin
    win_n = win;
    if (take) begin
      win_n = '0;
      win_n[HIST_BITS+SAMPLE_WIDTH-1:0] = hist_ext;
    end else if (state == CAPTURE && valid_i) begin
      win_n = {win[WIN_BITS-SAMPLE_WIDTH-1:0], sample_i};
    end
  end

  assign frame_vec = {take ? ts : ts_q, take ? fir_i : fir_q, win_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      ts       <= '0;
      ts_q     <= '0;
      fir_q    <= '0;
      hist     <= '0;
      win      <= '0;
      post_cnt <= '0;
      hold_cnt <= '0;
      missed_o <= '0;
    end else begin
      ts  <= ts + TIME_WIDTH'(1);
      win <= win_n;
      if (valid_i) hist <= hist_ext[HIST_BITS-1:0];
      if (take) begin
        ts_q     <= ts;
        fir_q    <= fir_i;
        post_cnt <= PW'(1);
      end else if (state == CAPTURE && valid_i) begin
        post_cnt <= post_cnt + PW'(1);
      end
      if (tx_done)                        hold_cnt <= '0;
      else if (state == HOLDOFF && valid_i) hold_cnt <= hold_cnt + 16'd1;
      if (trig && state != IDLE && missed_o != 8'hFF) missed_o <= missed_o + 8'd1;
    end
  end

`ifdef PDW_CRC_EN
  logic [15:0] crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  // CRC tracks the data bits as they leave, then itself shifts out behind them.
  always_ff @(posedge clk) begin
    if (rst)       crc <= 16'hFFFF;
    else if (load) crc <= crc_step(16'hFFFF, frame_vec[DATA_BITS-1]);
    else if (state == TX && !tx_done) begin
      if (bit_cnt < CW'(DATA_BITS)) crc <= crc_step(crc, sr[DATA_BITS-1]);
      else                          crc <= {crc[14:0], 1'b0};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pdw_frame <= 1'b0;
      pdw_data  <= 1'b0;
      bit_cnt   <= '0;
      sr        <= '0;
    end else if (load) begin
      pdw_frame <= 1'b1;
      pdw_data  <= frame_vec[DATA_BITS-1];
      sr        <= frame_vec << 1;
      bit_cnt   <= CW'(1);
    end else if (state == TX) begin
      if (tx_done) begin
        pdw_frame <= 1'b0;
        pdw_data  <= 1'b0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
        if (bit_cnt < CW'(DATA_BITS)) begin
          pdw_data <= sr[DATA_BITS-1];
          sr       <= sr << 1;
        end
`ifdef PDW_CRC_EN
        else pdw_data <= crc[15];
`endif
      end
    end
  end
endmodule

// File: tb/tb_pdw_snapshot_engine.sv
// Bench for pdw_snapshot_engine: frame-level reference model compared every cycle, plus literal checks.
module tb_pdw_snapshot_engine;
  localparam int SW = 16, FW = 36, PRE = 4, POST = 6, TW = 32, W = PRE + POST;
`ifdef PDW_CRC_EN
  localparam int LEN = TW + FW + W * SW + 16;
`else
  localparam int LEN = TW + FW + W * SW;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic [SW-1:0] sample_i = '0;
  logic [FW-1:0] fir_i = '0, hi = '0, lo = '0;
  logic          valid_i = 1'b0, en = 1'b0;
  logic [15:0]   holdoff = '0;
  logic          pdw_data, pdw_frame, busy_o;
  logic [7:0]    missed_o;

  int n_cmp = 0, n_fail = 0, cc = 0, next_s = 1;
  bit chk_en = 0;

  pdw_snapshot_engine dut (
    .clk(clk), .rst(rst), .sample_i(sample_i), .fir_i(fir_i), .valid_i(valid_i),
    .cfg_en_i(en), .cfg_thresh_hi_i(hi), .cfg_thresh_lo_i(lo), .cfg_holdoff_i(holdoff),
    .pdw_data(pdw_data), .pdw_frame(pdw_frame), .busy_o(busy_o), .missed_o(missed_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cc);
    end
  endtask

  // ---------------- reference model: whole-frame bit queue per trigger ----------------
  typedef enum int {M_IDLE, M_COLLECT, M_TX, M_HOLD} mph_t;
  mph_t   ph = M_IDLE;
  longint m_ts = 0, t_ts = 0, t_fir = 0;
  int     m_missed = 0, hold_seen = 0;
  int     hist_q[$], win_q[$];
  bit     txq[$];
  bit     e_frame = 0, e_data = 0, e_busy = 0;

  task automatic push_field(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) txq.push_back(v[i]);
  endtask

  task automatic start_frame();
    logic [15:0] c;
    bit fb;
    txq.delete();
    push_field(t_ts, TW);
    push_field(t_fir, FW);
    foreach (win_q[k]) push_field(win_q[k], SW);
`ifdef PDW_CRC_EN
    c = 16'hFFFF;
    foreach (txq[i]) begin
      fb = c[15] ^ txq[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    push_field(c, 16);
`endif
    ph      = M_TX;
    e_frame = 1;
    e_data  = txq.pop_front();
  endtask

  task automatic model_step();
    bit hit;
    longint f;
    if (rst) begin
      ph = M_IDLE; m_ts = 0; m_missed = 0;
      txq.delete(); win_q.delete(); hist_q.delete();
      repeat (PRE) hist_q.push_back(0);
      e_frame = 0; e_data = 0; e_busy = 0;
      return;
    end
    f   = longint'($signed(fir_i));
    hit = valid_i && en && (f >= longint'($signed(hi)) || f <= longint'($signed(lo)));
    if (hit && ph != M_IDLE && m_missed < 255) m_missed++;
    case (ph)
      M_IDLE: if (hit) begin
        t_ts = m_ts; t_fir = f;
        win_q = hist_q;
        win_q.push_back(int'(sample_i));
        if (win_q.size() == W) start_frame(); else ph = M_COLLECT;
      end
      M_COLLECT: if (valid_i) begin
        win_q.push_back(int'(sample_i));
        if (win_q.size() == W) start_frame();
      end
      M_TX: if (txq.size() > 0) e_data = txq.pop_front();
            else begin
              e_frame = 0; e_data = 0; hold_seen = 0;
              ph = (holdoff == 0) ? M_IDLE : M_HOLD;
            end
      M_HOLD: if (valid_i) begin
        hold_seen++;
        if (hold_seen >= int'(holdoff)) ph = M_IDLE;
      end
      default: ph = M_IDLE;
    endcase
    if (valid_i) begin
      hist_q.push_back(int'(sample_i));
      void'(hist_q.pop_front());
    end
    m_ts++;
    e_busy = (ph != M_IDLE);
  endtask

  initial forever begin
    @(posedge clk);
    cc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("pdw_frame", pdw_frame, e_frame);
      chk("pdw_data", pdw_data, e_data);
      chk("busy_o", busy_o, e_busy);
      chk("missed_o", missed_o, m_missed);
    end
  end

  // ---------------- frame collector: decodes what the DUT actually sent ----------------
  bit     cur[$];
  int     cur_len = 0, frames_seen = 0, last_len = 0, rise_edge = 0;
  bit     discard = 0;
  longint last_ts = 0, last_fir = 0;
  int     last_samp[W];

  initial forever begin
    logic [63:0] v;
    int p;
    @(negedge clk);
    if (pdw_frame === 1'b1) begin
      if (cur.size() == 0) rise_edge = cc;
      cur.push_back(pdw_data);
    end else if (cur.size() > 0) begin
      if (discard) discard = 0;
      else begin
        last_len = cur.size();
        p = 0;
        v = '0; for (int i = 0; i < TW; i++) begin v = {v[62:0], cur[p]}; p++; end
        last_ts = longint'(v);
        v = '0; for (int i = 0; i < FW; i++) begin v = {v[62:0], cur[p]}; p++; end
        last_fir = longint'($signed(v[FW-1:0]));
        for (int k = 0; k < W; k++) begin
          v = '0; for (int i = 0; i < SW; i++) begin v = {v[62:0], cur[p]}; p++; end
          last_samp[k] = int'(v[SW-1:0]);
        end
        frames_seen++;
      end
      cur.delete();
    end
    cur_len = cur.size();
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input longint f);
    @(negedge clk);
    valid_i = v;
    fir_i   = f[FW-1:0];
    if (v) begin sample_i = next_s[SW-1:0]; next_s++; end
    else sample_i = 16'hDEAD;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1; valid_i = 0; fir_i = '0;
    repeat (n) @(negedge clk);
    chk("reset pdw_frame", pdw_frame, 0);
    chk("reset pdw_data", pdw_data, 0);
    chk("reset busy_o", busy_o, 0);
    chk("reset missed_o", missed_o, 0);
    rst = 0;
    next_s = 1;
  endtask

  initial begin
    int t_edge, trig_s, base, sa;
    bit ok;
    longint tmp;
    hi = 36'd1000;
    tmp = -1000; lo = tmp[FW-1:0];
    en = 1;
    do_reset(3);
    chk_en = 1;

    // single high trigger on sample 5, continuous valid
    for (int i = 1; i <= 4; i++) drive(1, 0);
    drive(1, 2000); t_edge = cc + 1;
    for (int i = 0; i < 400 && frames_seen < 1; i++) drive(1, 0);
    chk("t1 frames", frames_seen, 1);
    chk("t1 len", last_len, LEN);
    chk("t1 fir", last_fir, 2000);
    chk("t1 ts", last_ts, 5);
    ok = 1; for (int k = 0; k < W; k++) if (last_samp[k] != k + 1) ok = 0;
    chk("t1 samples 1..10", ok, 1);
    chk("t1 frame rise latency", rise_edge - t_edge, 5);

    // low trigger with valid toggling every other cycle
    base = frames_seen;
    drive(0, 0); drive(1, 0); drive(0, 0); drive(1, 0); drive(0, 0);
    drive(1, -1500); t_edge = cc + 1; trig_s = next_s - 1;
    for (int i = 0; i < 400 && frames_seen == base; i++) begin drive(0, 0); drive(1, 0); end
    chk("t2 frames", frames_seen, base + 1);
    chk("t2 fir", last_fir, -1500);
    chk("t2 trigger sample", last_samp[PRE], trig_s);
    ok = 1; for (int k = 1; k < W; k++) if (last_samp[k] != last_samp[k-1] + 1) ok = 0;
    chk("t2 window valid-only", ok, 1);
    chk("t2 frame rise latency", rise_edge - t_edge, 10);

    // 300 hits while busy: missed saturates, single frame
    holdoff = 16'd100;
    base = frames_seen;
    repeat (300) drive(1, 2000);
    for (int i = 0; i < 400 && busy_o; i++) drive(1, 0);
    chk("t3 back to idle", busy_o, 0);
    chk("t3 missed saturated", missed_o, 255);
    chk("t3 one frame", frames_seen, base + 1);

    // holdoff=3 with sustained hits
    holdoff = 16'd3;
    base = frames_seen;
    for (int i = 0; i < 400 && frames_seen == base; i++) drive(1, 2000);
    sa = last_samp[PRE];
    repeat (6) drive(1, 2000);
    for (int i = 0; i < 400 && frames_seen < base + 2; i++) drive(1, 0);
    chk("t4 frames", frames_seen, base + 2);
    chk("t4 holdoff sample gap", last_samp[PRE] - sa, LEN + 9);
    for (int i = 0; i < 400 && busy_o; i++) drive(1, 0);

    // disarmed: hits ignored
    en = 0;
    repeat (5) drive(1, 2000);
    chk("disarmed busy_o", busy_o, 0);
    en = 1;

    // reset around bit 100 of a frame
    holdoff = 16'd0;
    drive(1, 2000);
    for (int i = 0; i < 400 && cur_len < 100; i++) drive(1, 0);
    chk("t5 reached bit 100", cur_len >= 100, 1);
    discard = 1;
    do_reset(1);
    base = frames_seen;
    drive(1, 2000);
    for (int i = 0; i < 400 && frames_seen == base; i++) drive(1, 0);
    chk("t5 frames", frames_seen, base + 1);
    ok = 1; for (int k = 0; k < PRE; k++) if (last_samp[k] != 0) ok = 0;
    chk("t5 pre zero", ok, 1);
    chk("t5 trigger sample", last_samp[PRE], 1);

    repeat (5) drive(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish, %0d compared", n_cmp);
    $fatal(1);
  end
endmodule

// File: doc/pdw_snapshot_engine.md
# pdw_snapshot_engine

Parametrised successor to the fixed 10-tap snapshot path of the FIR front end. It accepts the FIR output stream and the aligned raw sample stream, and triggers on a high or low threshold crossing. On a trigger it captures a pre-/post-trigger sample window with a timestamp, then serialises the result as a Pulse Descriptor Word (PDW) on the `pdw_data`/`pdw_frame` pins. Window depth, widths and holdoff are generalised, and missed triggers are counted.

## Interface
- `SAMPLE_WIDTH`, default 16: raw sample width in bits.
- `FIR_WIDTH`, default 36: signed FIR result width in bits.
- `PRE_SAMPLES`, default 4: samples captured before the trigger sample; ≥1.
- `POST_SAMPLES`, default 6: samples captured from the trigger sample onward, trigger included; ≥1.
- `TIME_WIDTH`, default 32: timestamp width in bits.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset; synchronous, active-high.
- `sample_i`, input, `SAMPLE_WIDTH`: raw sample, aligned with `fir_i`.
- `fir_i`, input, `FIR_WIDTH`: signed FIR output.
- `valid_i`, input, 1: `sample_i`/`fir_i` valid this cycle.
- `cfg_en_i`, input, 1: arm triggering.
- `cfg_thresh_hi_i`, input, `FIR_WIDTH`: signed high threshold; trigger when `fir_i >= hi`.
- `cfg_thresh_lo_i`, input, `FIR_WIDTH`: signed low threshold; trigger when `fir_i <= lo`.
- `cfg_holdoff_i`, input, 16: valid samples ignored after a frame ends.
- `pdw_data`, output, 1: serial PDW bit, MSB first.
- `pdw_frame`, output, 1: high for every bit of a frame.
- `busy_o`, output, 1: state is not IDLE.
- `missed_o`, output, 8: saturating count of triggers dropped while busy.

## Operation
- W = PRE_SAMPLES + POST_SAMPLES.
- History shift register of PRE_SAMPLES entries:
  - Advances only on `valid_i`.
  - Entries are zero after reset.
- Timestamp counter of TIME_WIDTH bits:
  - Increments every clk and wraps.
  - Cleared by reset.
- Trigger condition: `valid_i & cfg_en_i & (hi_hit | lo_hit)`. If both thresholds hit in the same cycle, one trigger is taken.
- States:
  - IDLE: on trigger, latch the timestamp, `fir_i` and the history; store `sample_i` as post[0]. Go to CAPTURE, or straight to TX if POST_SAMPLES=1.
  - CAPTURE: each `valid_i` stores the next post sample. After post[POST_SAMPLES-1] is stored, go to TX.
  - TX: shift out one bit per clk. After the last bit, go to HOLDOFF, or to IDLE if `cfg_holdoff_i`=0.
  - HOLDOFF: count `cfg_holdoff_i` `valid_i` cycles, then go to IDLE.
- Frame field order, each field MSB first:
  - timestamp (TIME_WIDTH);
  - trigger FIR value (FIR_WIDTH);
  - W samples, oldest first;
  - CRC16, when compiled in.
- Frame length at defaults: 32+36+160+16 = 244 bits.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, computed over all preceding frame bits.
- Missed triggers:
  - Any trigger condition outside IDLE increments `missed_o`, which saturates at 255.
  - `missed_o` is cleared only by reset.
- `cfg_en_i` deasserted mid-operation: the current capture and frame complete normally; no new triggers are taken.
- Config inputs are sampled live. Thresholds and holdoff are used as presented on the cycle they are evaluated.

## Timing
- Reset values: `pdw_data`=0, `pdw_frame`=0, `busy_o`=0, `missed_o`=0; state IDLE.
- Reset mid-frame: `pdw_frame` is low from the cycle after the reset edge. No partial frame resumes.
- `busy_o` rises the cycle after the trigger cycle.
- `pdw_frame` rises the cycle after the final post sample is stored. With POST_SAMPLES=1 this is the cycle after the trigger.
- `pdw_frame` stays high for exactly the frame-length cycles, with no gaps.
- `pdw_data` is registered and changes only with `pdw_frame` high. It is 0 when `pdw_frame` is low.
- Consecutive frames are separated by at least one idle cycle.
- A trigger on the cycle IDLE is re-entered is accepted. A trigger on the last HOLDOFF cycle is counted as missed.

## Configuration
- `PDW_CRC_EN` defined: the 16-bit CRC is appended after the last sample (244 bits at defaults).
- `PDW_CRC_EN` undefined: no CRC logic is built and the frame ends after the last sample (228 bits at defaults).

## Test plan
- Single high trigger:
  - Stimulus: defaults, `PDW_CRC_EN` defined, hi=1000, lo=-1000. Ramp samples 1,2,3,…; `fir_i`=2000 on the sample-5 cycle; `valid_i`=1 throughout.
  - Response: one 244-bit frame. Samples decode as 1..10, FIR field reads 2000, and the CRC matches the reference model.
- Low trigger with gapped valid:
  - Stimulus: `fir_i`=-1500, `valid_i` toggling every other cycle.
  - Response: the post window collects only the valid samples. `pdw_frame` rises one cycle after the 6th post sample.
- Triggers while busy:
  - Stimulus: 300 further threshold hits during CAPTURE, TX and HOLDOFF.
  - Response: `missed_o`=255 (saturated); no extra frame is produced.
- Holdoff:
  - Stimulus: holdoff=3, sustained `fir_i` above hi.
  - Response: the next frame's trigger sample is the 4th valid sample after the previous frame ends.
- Reset at bit 100 of a frame:
  - Response: `pdw_frame`, `busy_o` and `missed_o` are 0 the next cycle. The history reads zero in the next frame's pre samples.
- `PDW_CRC_EN` undefined:
  - Stimulus: same as the single-high-trigger test.
  - Response: a 228-bit frame with identical leading bits.
